adc_acq_capture: RTL and testbench
==================================

ADC_ACQ_CAPTURE -- requirements
Module: adc_acq_capture

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, number of ADC channels captured in parallel.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, sample width per channel, excluding the overrange bit.
REQ-003 SHALL have parameter DEPTH, default 1024, samples per channel; power of two, 16..65536; AW = log2(DEPTH).
REQ-004 SHALL have port sys_clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port sample_valid_i  input  1  one sample per channel present this cycle.
REQ-007 SHALL have port sample_data_i  input  NUM_CHANNELS*(DATA_WIDTH+1)  per-channel {ov, data}; channel 0 in the LSBs.
REQ-008 SHALL have port trigger_i  input  1  external trigger; level, rising-edge sensitive.
REQ-009 SHALL have port sw_trig_i  input  1  software trigger pulse.
REQ-010 SHALL have port arm_i  input  1  pulse that starts a capture.
REQ-011 SHALL have port abort_i  input  1  pulse that returns the block to IDLE.
REQ-012 SHALL have port pre_samples_i  input  AW+1  samples to keep before the trigger.
REQ-013 SHALL have port post_samples_i  input  AW+1  samples to keep from the trigger onward.
REQ-014 SHALL have port state_o  output  3  current state encoding.
REQ-015 SHALL have port done_o  output  1  high while in DONE.
REQ-016 SHALL have port ov_sticky_o  output  NUM_CHANNELS  sticky per-channel overrange flags.
REQ-017 SHALL have port rd_en_i  input  1  read request.
REQ-018 SHALL have port rd_addr_i  input  AW  logical read index; 0 = oldest captured sample.
REQ-019 SHALL have port rd_data_o  output  NUM_CHANNELS*(DATA_WIDTH+1)  read data.
REQ-020 SHALL have port rd_valid_o  output  1  rd_data_o valid.

Function
REQ-021 SHALL sample pre_samples_i and post_samples_i on arm_i; set pre = min(pre_i, DEPTH) and post = min(post_i, DEPTH-pre).
REQ-022 SHALL implement the states IDLE(0), PRE(1), WAIT(2), POST(3) and DONE(4).
REQ-023 SHALL, from IDLE or DONE on arm_i, clear the write pointer, sample counter and ov_sticky_o, then go to PRE, or to WAIT if pre = 0.
REQ-024 SHALL, in PRE/WAIT/POST, write every sample_valid_i cycle to RAM[wptr] and increment wptr modulo DEPTH.
REQ-025 SHALL leave PRE for WAIT after pre samples have been written; triggers during PRE are ignored.
REQ-026 SHALL, in WAIT, treat a trigger as a trigger_i 0->1 edge (registered previous value) OR sw_trig_i.
REQ-027 SHALL, on a trigger in WAIT, latch trig_ptr = wptr of that cycle; that cycle's sample, if valid, is post sample 0.
REQ-028 SHALL go to POST on the trigger, or directly to DONE if post = 0.
REQ-029 SHALL go to DONE when post samples (counted from the trigger cycle) have been written.
REQ-030 SHALL perform no writes in IDLE or DONE.
REQ-031 SHALL, in WAIT, keep overwriting the circular buffer without limit.
REQ-032 SHALL return to IDLE on abort_i from any state; abort_i SHALL take priority over arm_i and triggers in the same cycle.
REQ-033 SHALL ignore arm_i in PRE, WAIT and POST.
REQ-034 SHALL OR each channel's ov bit into ov_sticky_o on every written sample.
REQ-035 SHALL compute read physical address = (trig_ptr - pre + rd_addr_i) mod DEPTH.
REQ-036 SHALL give reads a latency of one cycle.
REQ-037 SHALL set rd_valid_o one cycle after rd_en_i only if the state was DONE at the request; otherwise rd_valid_o = 0 and rd_data_o is don't-care.
REQ-038 SHALL treat rd_addr_i >= pre+post as undefined data.

Reset
REQ-039 SHALL, on rst, enter IDLE with state_o=0, done_o=0, ov_sticky_o=0, rd_valid_o=0, wptr=0, trig_ptr=0, and registered trigger=0.
REQ-040 SHALL, on rst mid-capture, discard the capture; RAM contents are not cleared.

Structure
REQ-041 SHALL place the state encoding constants and a clog2 function in shared package adc_acq_pkg.
REQ-042 SHALL implement storage as sub-module adc_acq_ram: simple dual-port, one write port and one registered read port, width NUM_CHANNELS*(DATA_WIDTH+1), inferable as block RAM.

Verification
REQ-043 SHALL cover: DEPTH=16, pre=4, post=8, ramp data 0,1,2…, trigger edge at sample 10 -> DONE; reads 0..11 return 6..17.
REQ-044 SHALL cover: pre=4, external trigger during PRE at sample 2 -> ignored, state stays PRE, WAIT entered after sample 3.
REQ-045 SHALL cover: pre=12, post=10 with DEPTH=16 -> post clamped to 4; DONE after 4 post samples.
REQ-046 SHALL cover: abort_i asserted in the same cycle as a trigger in WAIT -> IDLE, no trig_ptr update, done_o=0.
REQ-047 SHALL cover: ov bit set on channel 2 for one sample during POST -> ov_sticky_o=4'b0100 until the next arm_i or rst.
REQ-048 SHALL cover: rd_en_i during WAIT -> rd_valid_o=0; rd_en_i in DONE -> rd_valid_o=1 exactly one cycle later.

Source files
------------

// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition capture block:
// state encoding and a constant-evaluable ceil(log2) helper.
package adc_acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Smallest r with 2**r >= value; used to size address fields.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_acq_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Written as a plain array with a clocked read so it maps onto block RAM.
module adc_acq_ram #(
    parameter int WIDTH = 68,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    logic [WIDTH-1:0] rd_data_reg;

    // Write port and registered read port share the one clock.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/adc_acq_capture.sv
// Multi-channel ADC capture with pre/post trigger windows into a circular
// buffer. Readback is relative to the oldest captured sample.
module adc_acq_capture
    import adc_acq_pkg::*;
#(
    parameter  int NUM_CHANNELS = 4,
    parameter  int DATA_WIDTH   = 16,
    parameter  int DEPTH        = 1024,
    localparam int AW           = clog2(DEPTH),
    localparam int SW           = NUM_CHANNELS * (DATA_WIDTH + 1)
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    input  logic                    sample_valid_i,
    input  logic [SW-1:0]           sample_data_i,
    input  logic                    trigger_i,
    input  logic                    sw_trig_i,
    input  logic                    arm_i,
    input  logic                    abort_i,
    input  logic [AW:0]             pre_samples_i,
    input  logic [AW:0]             post_samples_i,
    output logic [2:0]              state_o,
    output logic                    done_o,
    output logic [NUM_CHANNELS-1:0] ov_sticky_o,
    input  logic                    rd_en_i,
    input  logic [AW-1:0]           rd_addr_i,
    output logic [SW-1:0]           rd_data_o,
    output logic                    rd_valid_o
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_V   = (AW+1)'(1);

    state_t                  state_reg;
    logic [AW-1:0]           wptr_reg;
    logic [AW-1:0]           trig_ptr_reg;
    logic [AW:0]             pre_reg;
    logic [AW:0]             post_reg;
    logic [AW:0]             cnt_reg;
    logic                    trig_prev_reg;
    logic [NUM_CHANNELS-1:0] ov_sticky_reg;
    logic                    rd_valid_reg;

    logic [AW:0]             pre_clamp;
    logic [AW:0]             post_room;
    logic [AW:0]             post_clamp;
    logic [AW:0]             cnt_inc;
    logic                    trig_evt;
    logic                    capturing;
    logic                    wr_en;
    logic [AW-1:0]           rd_phys;
    logic [NUM_CHANNELS-1:0] sample_ov;

    // Window sizes are clamped so pre+post never exceeds the buffer.
    assign pre_clamp  = (pre_samples_i > DEPTH_V) ? DEPTH_V : pre_samples_i;
    assign post_room  = DEPTH_V - pre_clamp;
    assign post_clamp = (post_samples_i > post_room) ? post_room : post_samples_i;

    assign cnt_inc   = cnt_reg + ONE_V;
    assign trig_evt  = (trigger_i & ~trig_prev_reg) | sw_trig_i;
    assign capturing = (state_reg == ST_PRE) || (state_reg == ST_WAIT) ||
                       (state_reg == ST_POST);

    // A trigger with an empty post window ends the capture without writing,
    // so a full-depth pre window is not overwritten by the trigger sample.
    assign wr_en = sample_valid_i && capturing && !abort_i &&
                   !((state_reg == ST_WAIT) && trig_evt && (post_reg == '0));

    // Per-channel overrange bit sits at the top of each {ov, data} slice.
    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ov
            assign sample_ov[gi] = sample_data_i[gi*(DATA_WIDTH+1) + DATA_WIDTH];
        end
    endgenerate

    // Capture control: window counting, write pointer, trigger latch, flags.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wptr_reg      <= '0;
            trig_ptr_reg  <= '0;
            pre_reg       <= '0;
            post_reg      <= '0;
            cnt_reg       <= '0;
            trig_prev_reg <= 1'b0;
            ov_sticky_reg <= '0;
        end else begin
            trig_prev_reg <= trigger_i;
            if (wr_en) begin
                wptr_reg      <= wptr_reg + 1'b1;
                ov_sticky_reg <= ov_sticky_reg | sample_ov;
            end
            if (abort_i) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE, ST_DONE: begin
                        if (arm_i) begin
                            pre_reg       <= pre_clamp;
                            post_reg      <= post_clamp;
                            wptr_reg      <= '0;
                            cnt_reg       <= '0;
                            ov_sticky_reg <= '0;
                            state_reg     <= (pre_clamp == '0) ? ST_WAIT : ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        if (sample_valid_i) begin
                            if (cnt_inc == pre_reg) begin
                                cnt_reg   <= '0;
                                state_reg <= ST_WAIT;
                            end else begin
                                cnt_reg <= cnt_inc;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (trig_evt) begin
                            trig_ptr_reg <= wptr_reg;
                            if (post_reg == '0) begin
                                state_reg <= ST_DONE;
                            end else if (sample_valid_i && (post_reg == ONE_V)) begin
                                state_reg <= ST_DONE;
                            end else begin
                                cnt_reg   <= sample_valid_i ? ONE_V : '0;
                                state_reg <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (sample_valid_i) begin
                            if (cnt_inc == post_reg) begin
                                state_reg <= ST_DONE;
                            end else begin
                                cnt_reg <= cnt_inc;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // Logical index 0 is the oldest sample of the pre window.
    assign rd_phys = trig_ptr_reg - pre_reg[AW-1:0] + rd_addr_i;

    // Read data is only declared valid for requests made while in DONE.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en_i && (state_reg == ST_DONE);
        end
    end

    adc_acq_ram #(
        .WIDTH (SW),
        .AW    (AW)
    ) u_ram (
        .clk     (sys_clk),
        .wr_en   (wr_en),
        .wr_addr (wptr_reg),
        .wr_data (sample_data_i),
        .rd_en   (rd_en_i),
        .rd_addr (rd_phys),
        .rd_data (rd_data_o)
    );

    assign state_o     = state_reg;
    assign done_o      = (state_reg == ST_DONE);
    assign ov_sticky_o = ov_sticky_reg;
    assign rd_valid_o  = rd_valid_reg;

endmodule

// File: tb/tb_adc_acq_capture.sv
// Directed bench for adc_acq_capture with a 16-deep buffer and 4 channels.
module tb_adc_acq_capture;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int SW  = NCH * (DW + 1);

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          sample_valid_i;
    logic [SW-1:0] sample_data_i;
    logic          trigger_i;
    logic          sw_trig_i;
    logic          arm_i;
    logic          abort_i;
    logic [4:0]    pre_samples_i;
    logic [4:0]    post_samples_i;
    logic [2:0]    state_o;
    logic          done_o;
    logic [3:0]    ov_sticky_o;
    logic          rd_en_i;
    logic [3:0]    rd_addr_i;
    logic [SW-1:0] rd_data_o;
    logic          rd_valid_o;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    adc_acq_capture #(
        .NUM_CHANNELS (NCH),
        .DATA_WIDTH   (DW),
        .DEPTH        (16)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .sample_valid_i (sample_valid_i),
        .sample_data_i  (sample_data_i),
        .trigger_i      (trigger_i),
        .sw_trig_i      (sw_trig_i),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .pre_samples_i  (pre_samples_i),
        .post_samples_i (post_samples_i),
        .state_o        (state_o),
        .done_o         (done_o),
        .ov_sticky_o    (ov_sticky_o),
        .rd_en_i        (rd_en_i),
        .rd_addr_i      (rd_addr_i),
        .rd_data_o      (rd_data_o),
        .rd_valid_o     (rd_valid_o)
    );

    // Sample word: channel c carries n + c*0x1000, with its ov bit on top.
    function automatic logic [SW-1:0] mk(input int n, input logic [3:0] ov);
        logic [SW-1:0] r;
        for (int c = 0; c < NCH; c++) begin
            r[c*17 +: 17] = {ov[c], 16'(n + c * 4096)};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic arm(input int pre, input int post);
        pre_samples_i  = 5'(pre);
        post_samples_i = 5'(post);
        sample_valid_i = 1'b0;
        arm_i          = 1'b1;
        tick();
        arm_i          = 1'b0;
    endtask

    task automatic send(input int n, input logic trig, input logic sw, input logic [3:0] ov);
        sample_valid_i = 1'b1;
        sample_data_i  = mk(n, ov);
        trigger_i      = trig;
        sw_trig_i      = sw;
        tick();
        sample_valid_i = 1'b0;
        sw_trig_i      = 1'b0;
    endtask

    task automatic do_read(input int a);
        rd_en_i   = 1'b1;
        rd_addr_i = 4'(a);
        tick();
        rd_en_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (state_o !== 3'd0 || done_o !== 1'b0 || ov_sticky_o !== 4'd0 || rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d done=%b ov=%b rd_valid=%b, required 0 0 0000 0",
                     state_o, done_o, ov_sticky_o, rd_valid_o);
        end
        $display("test_reset: state=%0d done=%b", state_o, done_o);
    endtask

    // pre=4, post=8, trigger edge at sample 10; reads 0..11 give 6..17.
    task automatic test_basic();
        arm(4, 8);
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL basic_arm_state: got %0d, required 1", state_o);
        end
        for (int i = 0; i < 4; i++) send(i, 1'b0, 1'b0, 4'd0);
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL basic_wait_state: got %0d, required 2", state_o);
        end
        for (int i = 4; i < 10; i++) send(i, 1'b0, 1'b0, 4'd0);
        send(10, 1'b1, 1'b0, 4'd0);
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL basic_post_state: got %0d, required 3", state_o);
        end
        for (int i = 11; i < 17; i++) send(i, 1'b1, 1'b0, 4'd0);
        checks++;
        if (state_o !== 3'd3 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_still_post: state=%0d done=%b, required 3 0", state_o, done_o);
        end
        send(17, 1'b1, 1'b0, 4'd0);
        trigger_i = 1'b0;
        checks++;
        if (state_o !== 3'd4 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_done: state=%0d done=%b, required 4 1", state_o, done_o);
        end
        for (int i = 0; i < 12; i++) begin
            do_read(i);
            checks++;
            if (rd_valid_o !== 1'b1 || rd_data_o !== mk(6 + i, 4'd0)) begin
                errors++;
                $display("FAIL basic_read[%0d]: valid=%b data=%h, required 1 %h",
                         i, rd_valid_o, rd_data_o, mk(6 + i, 4'd0));
            end
        end
        $display("test_basic: state=%0d trig_read0=%h", state_o, mk(6, 4'd0));
    endtask

    // Trigger edge during PRE is ignored; held level does not fire in WAIT.
    task automatic test_pre_trigger_ignored();
        arm(4, 2);
        send(100, 1'b0, 1'b0, 4'd0);
        send(101, 1'b0, 1'b0, 4'd0);
        send(102, 1'b1, 1'b0, 4'd0);
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL pretrig_stays_pre: got %0d, required 1", state_o);
        end
        send(103, 1'b1, 1'b0, 4'd0);
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL pretrig_wait_after_3: got %0d, required 2", state_o);
        end
        send(104, 1'b1, 1'b0, 4'd0);
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL pretrig_level_no_edge: got %0d, required 2", state_o);
        end
        send(105, 1'b1, 1'b1, 4'd0);
        send(106, 1'b1, 1'b0, 4'd0);
        trigger_i = 1'b0;
        checks++;
        if (state_o !== 3'd4) begin
            errors++;
            $display("FAIL pretrig_done: got %0d, required 4", state_o);
        end
        do_read(0);
        checks++;
        if (rd_data_o !== mk(101, 4'd0)) begin
            errors++;
            $display("FAIL pretrig_read0: got %h, required %h", rd_data_o, mk(101, 4'd0));
        end
        do_read(5);
        checks++;
        if (rd_data_o !== mk(106, 4'd0)) begin
            errors++;
            $display("FAIL pretrig_read5: got %h, required %h", rd_data_o, mk(106, 4'd0));
        end
        $display("test_pre_trigger_ignored: state=%0d", state_o);
    endtask

    // pre=12, post=10 on a 16-deep buffer: post clamps to 4, buffer wraps.
    task automatic test_clamp();
        arm(12, 10);
        for (int i = 0; i < 11; i++) send(200 + i, 1'b0, 1'b0, 4'd0);
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL clamp_pre_11: got %0d, required 1", state_o);
        end
        send(211, 1'b0, 1'b0, 4'd0);
        send(212, 1'b0, 1'b0, 4'd0);
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL clamp_wait: got %0d, required 2", state_o);
        end
        send(213, 1'b0, 1'b1, 4'd0);
        send(214, 1'b0, 1'b0, 4'd0);
        send(215, 1'b0, 1'b0, 4'd0);
        checks++;
        if (state_o !== 3'd3) begin
            errors++;
            $display("FAIL clamp_post_after3: got %0d, required 3", state_o);
        end
        send(216, 1'b0, 1'b0, 4'd0);
        checks++;
        if (state_o !== 3'd4) begin
            errors++;
            $display("FAIL clamp_done_after4: got %0d, required 4", state_o);
        end
        do_read(0);
        checks++;
        if (rd_data_o !== mk(201, 4'd0)) begin
            errors++;
            $display("FAIL clamp_read0: got %h, required %h", rd_data_o, mk(201, 4'd0));
        end
        do_read(11);
        checks++;
        if (rd_data_o !== mk(212, 4'd0)) begin
            errors++;
            $display("FAIL clamp_read11: got %h, required %h", rd_data_o, mk(212, 4'd0));
        end
        do_read(15);
        checks++;
        if (rd_data_o !== mk(216, 4'd0)) begin
            errors++;
            $display("FAIL clamp_read15: got %h, required %h", rd_data_o, mk(216, 4'd0));
        end
        $display("test_clamp: state=%0d", state_o);
    endtask

    // Abort wins over a same-cycle trigger and over a same-cycle arm.
    task automatic test_abort_trigger();
        arm(2, 4);
        send(500, 1'b0, 1'b0, 4'd0);
        send(501, 1'b0, 1'b0, 4'd0);
        abort_i = 1'b1;
        send(502, 1'b1, 1'b0, 4'd0);
        abort_i = 1'b0;
        trigger_i = 1'b0;
        checks++;
        if (state_o !== 3'd0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: state=%0d done=%b, required 0 0", state_o, done_o);
        end
        checks++;
        if (dut.trig_ptr_reg !== 4'd13) begin
            errors++;
            $display("FAIL abort_trig_ptr: got %0d, required 13", dut.trig_ptr_reg);
        end
        abort_i = 1'b1;
        arm(2, 4);
        abort_i = 1'b0;
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL abort_over_arm: got %0d, required 0", state_o);
        end
        $display("test_abort_trigger: state=%0d", state_o);
    endtask

    // Reads are only valid for requests issued while in DONE.
    task automatic test_read_gating();
        arm(2, 2);
        send(300, 1'b0, 1'b0, 4'd0);
        send(301, 1'b0, 1'b0, 4'd0);
        do_read(0);
        checks++;
        if (rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_in_wait: valid=%b, required 0", rd_valid_o);
        end
        send(302, 1'b1, 1'b0, 4'd0);
        send(303, 1'b1, 1'b0, 4'd0);
        trigger_i = 1'b0;
        checks++;
        if (state_o !== 3'd4 || rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_done_idle: state=%0d valid=%b, required 4 0", state_o, rd_valid_o);
        end
        do_read(0);
        checks++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== mk(300, 4'd0)) begin
            errors++;
            $display("FAIL rd_in_done: valid=%b data=%h, required 1 %h",
                     rd_valid_o, rd_data_o, mk(300, 4'd0));
        end
        tick();
        checks++;
        if (rd_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_one_cycle: valid=%b, required 0", rd_valid_o);
        end
        $display("test_read_gating: state=%0d", state_o);
    endtask

    // A single ov sample on channel 2 sticks until the next arm.
    task automatic test_ov_sticky();
        arm(2, 4);
        send(400, 1'b0, 1'b0, 4'd0);
        send(401, 1'b0, 1'b0, 4'd0);
        send(402, 1'b1, 1'b0, 4'd0);
        checks++;
        if (ov_sticky_o !== 4'b0000) begin
            errors++;
            $display("FAIL ov_before: got %b, required 0000", ov_sticky_o);
        end
        send(403, 1'b1, 1'b0, 4'b0100);
        checks++;
        if (ov_sticky_o !== 4'b0100) begin
            errors++;
            $display("FAIL ov_set: got %b, required 0100", ov_sticky_o);
        end
        send(404, 1'b1, 1'b0, 4'd0);
        send(405, 1'b1, 1'b0, 4'd0);
        trigger_i = 1'b0;
        tick();
        checks++;
        if (ov_sticky_o !== 4'b0100 || state_o !== 3'd4) begin
            errors++;
            $display("FAIL ov_held: ov=%b state=%0d, required 0100 4", ov_sticky_o, state_o);
        end
        arm(2, 4);
        checks++;
        if (ov_sticky_o !== 4'b0000 || state_o !== 3'd1) begin
            errors++;
            $display("FAIL ov_cleared_on_arm: ov=%b state=%0d, required 0000 1", ov_sticky_o, state_o);
        end
        $display("test_ov_sticky: ov=%b", ov_sticky_o);
    endtask

    // Reset while capturing returns to IDLE.
    task automatic test_reset_mid();
        send(600, 1'b0, 1'b0, 4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (state_o !== 3'd0 || ov_sticky_o !== 4'd0 || dut.trig_ptr_reg !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: state=%0d ov=%b trig_ptr=%0d, required 0 0000 0",
                     state_o, ov_sticky_o, dut.trig_ptr_reg);
        end
        $display("test_reset_mid: state=%0d", state_o);
    endtask

    initial begin
        rst            = 1'b1;
        sample_valid_i = 1'b0;
        sample_data_i  = '0;
        trigger_i      = 1'b0;
        sw_trig_i      = 1'b0;
        arm_i          = 1'b0;
        abort_i        = 1'b0;
        pre_samples_i  = '0;
        post_samples_i = '0;
        rd_en_i        = 1'b0;
        rd_addr_i      = '0;

        test_reset();
        test_basic();
        test_pre_trigger_ignored();
        test_clamp();
        test_abort_trigger();
        test_read_gating();
        test_ov_sticky();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
